// File: rtl/taintcell_fifo.sv
// Shadow taint tracker for a first-word-fall-through FIFO: per-entry taint
// storage, shadow pointers/count, sticky occupancy taint and live tainted-entry count.
module taintcell_fifo #(
  parameter int    WIDTH = 64,
  parameter int    DEPTH = 8,
  parameter string MODE  = "precise",
  localparam int   CNT_W = $clog2(DEPTH+1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             PUSH,
  input  logic             POP,
  input  logic             FLUSH,
  input  logic             PUSH_taint,
  input  logic             POP_taint,
  input  logic [WIDTH-1:0] DATA_IN_taint,
  output logic [WIDTH-1:0] DATA_OUT_taint,
  output logic             FULL_taint,
  output logic             EMPTY_taint,
  output logic [CNT_W-1:0] COUNT,
  output logic [CNT_W-1:0] taint_sum
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_CNT = CNT_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  generate
    if (MODE != "precise" && MODE != "conservative") begin : g_bad_mode
      $error("taintcell_fifo: unknown MODE '%s'", MODE);
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, r_sum;
  logic             r_occ;

  // Controls are compared against a known 1 so an X request acts as idle.
  logic w_rst, w_flush, w_push, w_pop, w_push_t, w_pop_t;
  assign w_rst    = (reset      === 1'b1);
  assign w_flush  = (FLUSH      === 1'b1);
  assign w_push   = (PUSH       === 1'b1);
  assign w_pop    = (POP        === 1'b1);
  assign w_push_t = (PUSH_taint === 1'b1);
  assign w_pop_t  = (POP_taint  === 1'b1);

  logic             w_push_ok, w_pop_ok, w_occ_set, w_occ_clr;
  logic [WIDTH-1:0] w_wdata, w_head, w_mode_term;
  logic             w_wr_nz, w_rd_nz;

  assign w_push_ok = w_push & (r_count != FULL_CNT);
  assign w_pop_ok  = w_pop  & (r_count != '0);
  assign w_wdata   = DATA_IN_taint | {WIDTH{w_push_t}};
  assign w_wr_nz   = |w_wdata;
  assign w_rd_nz   = |r_mem[r_rd_ptr];
  assign w_occ_set = (w_push_ok & w_push_t) | (w_pop_ok & w_pop_t);
  // Only a clean pop that actually drains the queue forgets occupancy taint.
  assign w_occ_clr = w_pop_ok & ~w_pop_t & ~w_push_ok & (r_count == ONE_CNT);

  always_ff @(posedge CLK) begin
    if (w_rst || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_sum    <= '0;
      r_occ    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // push_ok & pop_ok implies 0<COUNT<DEPTH, so the two slots differ.
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_mem[r_rd_ptr] <= '0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
      r_sum   <= r_sum + CNT_W'(w_push_ok & w_wr_nz) - CNT_W'(w_pop_ok & w_rd_nz);
      if (w_occ_set)      r_occ <= 1'b1;
      else if (w_occ_clr) r_occ <= 1'b0;
    end
  end

  generate
    if (MODE == "conservative") begin : g_cons
      assign w_mode_term = {WIDTH{r_occ}};
    end else begin : g_prec
      assign w_mode_term = '0;
    end
  endgenerate

  assign w_head         = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign DATA_OUT_taint = w_head | w_mode_term;
  assign FULL_taint     = r_occ & ((r_count == FULL_CNT) | (r_count == ALMOST_CNT));
  assign EMPTY_taint    = r_occ & (r_count <= ONE_CNT);
  assign COUNT          = r_count;
  assign taint_sum      = r_sum;

endmodule

// File: tb/tb_taintcell_fifo.sv
// Directed bench: precise and conservative trackers driven side by side,
// outputs compared against hand-computed values.
module tb_taintcell_fifo;
  localparam int W = 8;
  localparam int D = 8;
  localparam int CW = $clog2(D+1);

  logic          CLK = 1'b0;
  logic          reset, PUSH, POP, FLUSH, PUSH_taint, POP_taint;
  logic [W-1:0]  DATA_IN_taint;
  logic [W-1:0]  p_dout, c_dout;
  logic          p_full, p_empty, c_full, c_empty;
  logic [CW-1:0] p_cnt, p_sum, c_cnt, c_sum;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  taintcell_fifo #(.WIDTH(W), .DEPTH(D), .MODE("precise")) u_prec (
    .CLK(CLK), .reset(reset), .PUSH(PUSH), .POP(POP), .FLUSH(FLUSH),
    .PUSH_taint(PUSH_taint), .POP_taint(POP_taint), .DATA_IN_taint(DATA_IN_taint),
    .DATA_OUT_taint(p_dout), .FULL_taint(p_full), .EMPTY_taint(p_empty),
    .COUNT(p_cnt), .taint_sum(p_sum));

  taintcell_fifo #(.WIDTH(W), .DEPTH(D), .MODE("conservative")) u_cons (
    .CLK(CLK), .reset(reset), .PUSH(PUSH), .POP(POP), .FLUSH(FLUSH),
    .PUSH_taint(PUSH_taint), .POP_taint(POP_taint), .DATA_IN_taint(DATA_IN_taint),
    .DATA_OUT_taint(c_dout), .FULL_taint(c_full), .EMPTY_taint(c_empty),
    .COUNT(c_cnt), .taint_sum(c_sum));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock with the given controls; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic rst, input logic fl, input logic pu, input logic po,
                     input logic pt, input logic pot, input logic [W-1:0] d);
    reset = rst; FLUSH = fl; PUSH = pu; POP = po;
    PUSH_taint = pt; POP_taint = pot; DATA_IN_taint = d;
    @(posedge CLK); #1;
    reset = 0; FLUSH = 0; PUSH = 0; POP = 0;
    PUSH_taint = 0; POP_taint = 0; DATA_IN_taint = '0;
  endtask

  task automatic push(input logic pt, input logic [W-1:0] d); cyc(0,0,1,0,pt,0,d); endtask
  task automatic pop(input logic pot);                        cyc(0,0,0,1,0,pot,'0); endtask
  task automatic do_reset();                                  cyc(1,0,0,0,0,0,'0); endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".p_dout"}, p_dout, 0);  chk({tag, ".c_dout"}, c_dout, 0);
    chk({tag, ".cnt"},    p_cnt,  0);  chk({tag, ".sum"},    p_sum,  0);
    chk({tag, ".full"},   p_full, 0);  chk({tag, ".empty"},  p_empty, 0);
    chk({tag, ".c_cnt"},  c_cnt,  0);  chk({tag, ".c_empty"}, c_empty, 0);
  endtask

  logic [W-1:0] drain [7];

  initial begin
    reset = 0; FLUSH = 0; PUSH = 0; POP = 0;
    PUSH_taint = 0; POP_taint = 0; DATA_IN_taint = '0;

    // 1: reset state, clean/tainted/clean data ordering
    do_reset();
    chk_all_zero("rst");
    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h00);
    chk("t1.cnt", p_cnt, 3);
    chk("t1.sum", p_sum, 1);
    chk("t1.dout", p_dout, 8'h00);
    pop(0);
    chk("t1.dout_ff", p_dout, 8'hFF);
    chk("t1.c_dout_ff", c_dout, 8'hFF);
    pop(0);
    chk("t1.dout_0", p_dout, 8'h00);
    chk("t1.sum0", p_sum, 0);
    chk("t1.cnt1", p_cnt, 1);

    // 2: fill, push+pop while full, wrap with alternating traffic
    do_reset();
    for (int i = 0; i < D; i++) push(0, W'(i));
    chk("t2.full_cnt", p_cnt, 8);
    chk("t2.full_sum", p_sum, 7);
    chk("t2.full_flag", p_full, 0);
    cyc(0, 0, 1, 1, 0, 0, 8'hAA);
    chk("t2.pp_cnt", p_cnt, 7);
    chk("t2.pp_head", p_dout, 8'h01);
    chk("t2.pp_sum", p_sum, 7);
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) push(0, W'(8'h10 + k));
      else            pop(0);
    end
    chk("t2.wrap_cnt", p_cnt, 7);
    chk("t2.wrap_sum", p_sum, 7);
    drain = '{8'h16, 8'h18, 8'h1A, 8'h1C, 8'h1E, 8'h20, 8'h22};
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t2.drain%0d", i), p_dout, drain[i]);
      pop(0);
    end
    chk("t2.drain_cnt", p_cnt, 0);
    chk("t2.drain_sum", p_sum, 0);
    chk("t2.drain_dout", p_dout, 0);

    // 3: tainted push sets occupancy taint, clean pop to empty clears it
    do_reset();
    push(1, 8'h00);
    chk("t3.dout", p_dout, 8'hFF);
    chk("t3.empty", p_empty, 1);
    chk("t3.full", p_full, 0);
    chk("t3.sum", p_sum, 1);
    chk("t3.c_dout", c_dout, 8'hFF);
    pop(0);
    chk("t3.cnt", p_cnt, 0);
    chk("t3.empty0", p_empty, 0);
    chk("t3.c_dout0", c_dout, 0);
    chk("t3.sum0", p_sum, 0);

    // 4: tainted pop on clean entries -> mode-dependent head taint
    do_reset();
    for (int i = 0; i < 4; i++) push(0, 8'h00);
    chk("t4.cnt4", p_cnt, 4);
    pop(1);
    chk("t4.c_dout", c_dout, 8'hFF);
    chk("t4.p_dout", p_dout, 8'h00);
    chk("t4.empty", c_empty, 0);
    chk("t4.full_n", c_full, 0);
    for (int i = 0; i < 4; i++) push(0, 8'h00);
    chk("t4.cnt7", c_cnt, 7);
    chk("t4.full7", c_full, 1);
    push(0, 8'h00);
    chk("t4.full8", p_full, 1);
    chk("t4.c_dout_hold", c_dout, 8'hFF);
    cyc(0, 1, 1, 0, 1, 0, 8'h0F);
    chk("t4.fl_cnt", c_cnt, 0);
    chk("t4.fl_c_dout", c_dout, 0);
    chk("t4.fl_full", c_full, 0);
    chk("t4.fl_sum", c_sum, 0);

    // 5: tainted pop on empty is rejected; push+pop on empty accepts push
    pop(1);
    chk("t5.cnt", p_cnt, 0);
    chk("t5.empty", p_empty, 0);
    chk("t5.c_dout", c_dout, 0);
    cyc(0, 0, 1, 1, 0, 0, 8'h3C);
    chk("t5.pp_cnt", p_cnt, 1);
    chk("t5.pp_dout", p_dout, 8'h3C);

    // 6: reset mid-traffic discards everything, including a same-cycle push
    do_reset();
    push(0, 8'h01); push(0, 8'h00); push(0, 8'h02); push(1, 8'h00); push(0, 8'h04);
    chk("t6.cnt", p_cnt, 5);
    chk("t6.sum", p_sum, 4);
    chk("t6.empty", p_empty, 0);
    cyc(1, 0, 1, 0, 1, 0, 8'hFF);
    chk_all_zero("t6.rst");
    cyc(0, 0, 0, 0, 0, 0, 8'h00);
    chk("t6.after_cnt", p_cnt, 0);
    chk("t6.after_c_dout", c_dout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
